// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds FSM state encoding, frame constants and default parameters.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

    localparam int   FILTER_DEF  = 8;
    localparam int   TIMEOUT_DEF = 25000;

endpackage

// File: rtl/ps2_keyboard_if.sv
// Byte output bundle of the PS/2 receiver towards the io block.
// kdata: last good byte; kdone: new-byte strobe; kerr: error strobe.
interface ps2_keyboard_if;

    logic [7:0] kdata;
    logic       kdone;
    logic       kerr;

    modport master (
        output kdata,
        output kdone,
        output kerr
    );

    modport slave (
        input kdata,
        input kdone,
        input kerr
    );

endinterface

// File: rtl/ps2_filter.sv
// Synchronises both PS/2 pins, deglitches the clock, detects falls.
// Ports: i_clk, i_rst_n, i_ps2_clk, i_ps2_dat -> o_fclk, o_fall, o_dat.
module ps2_filter #(
    parameter int FILTER = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_fclk,
    output logic o_fall,
    output logic o_dat
);

    localparam int CW = $clog2(FILTER + 1);

    logic [1:0]    r_csync;
    logic [1:0]    r_dsync;
    logic          r_fclk;
    logic          r_fclk_d;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive samples that disagree with r_fclk;
    // any agreeing sample restarts the count, so short pulses vanish.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csync  <= 2'b11;
            r_dsync  <= 2'b11;
            r_fclk   <= 1'b1;
            r_fclk_d <= 1'b1;
            r_fall   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_csync  <= {r_csync[0], i_ps2_clk};
            r_dsync  <= {r_dsync[0], i_ps2_dat};
            r_fclk_d <= r_fclk;
            r_fall   <= r_fclk_d & ~r_fclk;
            if (r_csync[1] == r_fclk) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER - 1)) begin
                r_fclk <= r_csync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_fclk = r_fclk;
    assign o_fall = r_fall;
    assign o_dat  = r_dsync[1];

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host frame receiver producing kdata/kdone/kerr.
// Ports: clock, reset_n, ps2_clk, ps2_dat, kbd (master byte bundle).
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FILTER  = FILTER_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           ps2_clk,
    input  logic           ps2_dat,
    ps2_keyboard_if.master kbd
);

    logic w_fclk;
    logic w_fall;
    logic w_dat;
    logic w_edge;

    ps2_filter #(
        .FILTER (FILTER)
    ) u_filter (
        .i_clk     (clock),
        .i_rst_n   (reset_n),
        .i_ps2_clk (ps2_clk),
        .i_ps2_dat (ps2_dat),
        .o_fclk    (w_fclk),
        .o_fall    (w_fall),
        .o_dat     (w_dat)
    );

    // A fall pulse always coincides with a low filtered clock.
    assign w_edge = w_fall & ~w_fclk;

    state_t      r_state, w_state;
    logic [7:0]  r_shreg, w_shreg;
    logic [2:0]  r_bitcnt, w_bitcnt;
    logic        r_perr, w_perr;
    logic [14:0] r_tcnt, w_tcnt;
    logic [7:0]  r_kdata, w_kdata;
    logic        r_kdone, w_kdone;
    logic        r_kerr, w_kerr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_perr   <= 1'b0;
            r_tcnt   <= '0;
            r_kdata  <= 8'h00;
            r_kdone  <= 1'b0;
            r_kerr   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_shreg  <= w_shreg;
            r_bitcnt <= w_bitcnt;
            r_perr   <= w_perr;
            r_tcnt   <= w_tcnt;
            r_kdata  <= w_kdata;
            r_kdone  <= w_kdone;
            r_kerr   <= w_kerr;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_shreg  = r_shreg;
        w_bitcnt = r_bitcnt;
        w_perr   = r_perr;
        w_kdata  = r_kdata;
        w_kdone  = 1'b0;
        w_kerr   = 1'b0;

        if (r_state == ST_IDLE || w_edge) begin
            w_tcnt = '0;
        end else begin
            w_tcnt = r_tcnt + 15'd1;
        end

        unique case (r_state)
            ST_IDLE: begin
                if (w_edge && w_dat == START_BIT) begin
                    w_state  = ST_DATA;
                    w_bitcnt = '0;
                end
            end
            ST_DATA: begin
                if (w_edge) begin
                    w_shreg  = {w_dat, r_shreg[7:1]};
                    w_bitcnt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'(DATA_BITS - 1)) begin
                        w_state = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (w_edge) begin
                    w_perr  = ~(^r_shreg ^ w_dat);
                    w_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_edge) begin
                    if (w_dat == STOP_BIT && !r_perr) begin
                        w_kdata = r_shreg;
                        w_kdone = 1'b1;
                    end else begin
                        w_kerr = 1'b1;
                    end
                    w_state = ST_IDLE;
                end
            end
        endcase

        // A bit arriving in the expiry cycle takes priority.
        if (r_state != ST_IDLE && !w_edge &&
            r_tcnt == 15'(TIMEOUT - 1)) begin
            w_state = ST_IDLE;
            w_kerr  = 1'b1;
            w_tcnt  = '0;
        end
    end

    assign kbd.kdata = r_kdata;
    assign kbd.kdone = r_kdone;
    assign kbd.kerr  = r_kerr;

endmodule
